// File: rtl/offnariscv_pkg.sv
// Shared core definitions: datapath width, default ROB depth and the
// reorder-buffer entry layout.
package offnariscv_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_DEPTH = 8;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] target;
    logic            done;
    logic            redirect;
  } rob_entry_t;

endpackage

// File: rtl/commit_rob.sv
// In-order commit reorder buffer: allocates at the tail, takes out-of-order
// completions from NUM_EU channels and retires from the head, flushing on redirect.
module commit_rob #(
  parameter int  DEPTH  = offnariscv_pkg::ROB_DEPTH,
  parameter int  NUM_EU = 4,
  parameter int  XLEN   = offnariscv_pkg::XLEN,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [4:0]               alloc_rd,
  input  logic [XLEN-1:0]          alloc_pc,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [NUM_EU-1:0]        eu_valid,
  input  logic [NUM_EU*TAG_W-1:0]  eu_tag,
  input  logic [NUM_EU*XLEN-1:0]   eu_data,
  input  logic [NUM_EU-1:0]        eu_redirect,
  input  logic [NUM_EU*XLEN-1:0]   eu_target,
  output logic                     commit_valid,
  input  logic                     commit_ready,
  output logic [4:0]               commit_rd,
  output logic [XLEN-1:0]          commit_data,
  output logic [XLEN-1:0]          commit_pc,
  output logic                     redirect_valid,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [TAG_W:0]           count
);
  import offnariscv_pkg::rob_entry_t;

  // Handshakes: a transfer happens on a cycle where valid && ready; valid never
  // depends on ready, and alloc_ready never depends on commit_ready.
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  rob_entry_t        r_rob [DEPTH];
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;

  logic              w_head_live;
  logic              w_alloc_fire;
  logic              w_commit_fire;
  logic              w_flush;
  logic [TAG_W-1:0]  w_eu_tag [NUM_EU];
  logic [TAG_W-1:0]  w_eu_off [NUM_EU];
  logic [NUM_EU-1:0] w_eu_take;

  assign w_head_live    = (r_count != '0) && r_rob[r_head].done;
  assign commit_valid   = w_head_live;
  assign redirect_valid = w_head_live && r_rob[r_head].redirect;
  assign alloc_ready    = (r_count != FULL_CNT) && !redirect_valid;
  assign alloc_tag      = r_tail;
  assign commit_rd      = r_rob[r_head].rd;
  assign commit_data    = r_rob[r_head].data;
  assign commit_pc      = r_rob[r_head].pc;
  assign redirect_pc    = r_rob[r_head].target;
  assign count          = r_count;

  assign w_alloc_fire  = alloc_valid && alloc_ready;
  assign w_commit_fire = commit_valid && commit_ready;
  assign w_flush       = w_commit_fire && r_rob[r_head].redirect;

  // A tag is live when its distance from the head is below the occupancy.
  always_comb begin
    for (int i = 0; i < NUM_EU; i++) begin
      w_eu_tag[i]  = eu_tag[i*TAG_W +: TAG_W];
      w_eu_off[i]  = w_eu_tag[i] - r_head;
      w_eu_take[i] = eu_valid[i] && ({1'b0, w_eu_off[i]} < r_count)
                     && !r_rob[w_eu_tag[i]].done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) r_rob[e] <= '0;
    end else if (w_flush) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_rob[e].done     <= 1'b0;
        r_rob[e].redirect <= 1'b0;
      end
    end else begin
      if (w_alloc_fire) begin
        r_rob[r_tail].rd       <= alloc_rd;
        r_rob[r_tail].pc       <= alloc_pc;
        r_rob[r_tail].done     <= 1'b0;
        r_rob[r_tail].redirect <= 1'b0;
      end
      // Walk channels high to low so the lowest index lands last on a shared tag.
      for (int i = NUM_EU - 1; i >= 0; i--) begin
        if (w_eu_take[i]) begin
          r_rob[w_eu_tag[i]].data     <= eu_data[i*XLEN +: XLEN];
          r_rob[w_eu_tag[i]].target   <= eu_target[i*XLEN +: XLEN];
          r_rob[w_eu_tag[i]].redirect <= eu_redirect[i];
          r_rob[w_eu_tag[i]].done     <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= r_head + 1'b1;
      r_tail  <= r_head + 1'b1;
      r_count <= '0;
    end else begin
      if (w_commit_fire) r_head <= r_head + 1'b1;
      if (w_alloc_fire)  r_tail <= r_tail + 1'b1;
      case ({w_alloc_fire, w_commit_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_rob.sv
// Directed bench for commit_rob at DEPTH=4: allocation, out-of-order completion,
// channel priority, redirect flush, full-buffer wrap and mid-stream reset.
module tb_commit_rob;
  localparam int DEPTH  = 4;
  localparam int NUM_EU = 4;
  localparam int XLEN   = 32;
  localparam int TAG_W  = $clog2(DEPTH);

  logic                    clk;
  logic                    rst;
  logic                    alloc_valid;
  logic                    alloc_ready;
  logic [4:0]              alloc_rd;
  logic [XLEN-1:0]         alloc_pc;
  logic [TAG_W-1:0]        alloc_tag;
  logic [NUM_EU-1:0]       eu_valid;
  logic [NUM_EU*TAG_W-1:0] eu_tag;
  logic [NUM_EU*XLEN-1:0]  eu_data;
  logic [NUM_EU-1:0]       eu_redirect;
  logic [NUM_EU*XLEN-1:0]  eu_target;
  logic                    commit_valid;
  logic                    commit_ready;
  logic [4:0]              commit_rd;
  logic [XLEN-1:0]         commit_data;
  logic [XLEN-1:0]         commit_pc;
  logic                    redirect_valid;
  logic [XLEN-1:0]         redirect_pc;
  logic [TAG_W:0]          count;

  int n_checks;
  int n_errors;
  logic [XLEN-1:0] exp_q[$];

  commit_rob #(.DEPTH(DEPTH), .NUM_EU(NUM_EU), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .eu_valid(eu_valid), .eu_tag(eu_tag), .eu_data(eu_data),
    .eu_redirect(eu_redirect), .eu_target(eu_target),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_rd(commit_rd), .commit_data(commit_data), .commit_pc(commit_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    alloc_pc    = '0;
    eu_valid    = '0;
    eu_tag      = '0;
    eu_data     = '0;
    eu_redirect = '0;
    eu_target   = '0;
  endtask

  // Advance one clock; inputs change just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    alloc_valid = 1'b0;
    eu_valid    = '0;
    eu_redirect = '0;
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    commit_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic do_alloc(input logic [4:0] rd, input logic [XLEN-1:0] pc,
                          input logic [TAG_W-1:0] exp_tag);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    alloc_pc    = pc;
    #1;
    check("alloc_ready", 64'(alloc_ready), 64'd1);
    check("alloc_tag", 64'(alloc_tag), 64'(exp_tag));
    step();
  endtask

  task automatic set_eu(input int ch, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data,
                        input logic redir, input logic [XLEN-1:0] target);
    eu_valid[ch]                 = 1'b1;
    eu_tag[ch*TAG_W +: TAG_W]    = tag;
    eu_data[ch*XLEN +: XLEN]     = data;
    eu_redirect[ch]              = redir;
    eu_target[ch*XLEN +: XLEN]   = target;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    apply_reset();

    // reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);

    // fill to DEPTH without committing
    for (int k = 0; k < DEPTH; k++) do_alloc(5'(k + 1), 32'h100 + 32'(4 * k), TAG_W'(k));
    check("full_count", 64'(count), 64'd4);
    alloc_valid = 1'b1;
    #1;
    check("full_alloc_ready", 64'(alloc_ready), 64'd0);
    step();
    check("full_count_hold", 64'(count), 64'd4);

    // out-of-order completion, in-order commit
    apply_reset();
    for (int k = 0; k < 3; k++) do_alloc(5'(k + 1), 32'h200 + 32'(4 * k), TAG_W'(k));
    set_eu(0, 2'd2, 32'h30, 1'b0, 32'h0);
    step();
    check("ooo_cv_after_t2", 64'(commit_valid), 64'd0);
    set_eu(1, 2'd1, 32'h20, 1'b0, 32'h0);
    step();
    check("ooo_cv_after_t1", 64'(commit_valid), 64'd0);
    set_eu(3, 2'd0, 32'h10, 1'b0, 32'h0);
    #1;
    check("ooo_cv_same_cycle", 64'(commit_valid), 64'd0);
    step();
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h30);
    commit_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [XLEN-1:0] exp_d;
      exp_d = exp_q.pop_front();
      check("ooo_commit_valid", 64'(commit_valid), 64'd1);
      check("ooo_commit_data", 64'(commit_data), 64'(exp_d));
      check("ooo_commit_rd", 64'(commit_rd), 64'(k + 1));
      check("ooo_commit_pc", 64'(commit_pc), 64'(32'h200 + 32'(4 * k)));
      step();
    end
    check("ooo_drained_count", 64'(count), 64'd0);
    check("ooo_drained_cv", 64'(commit_valid), 64'd0);
    commit_ready = 1'b0;

    // channel priority on a shared tag, stale and unallocated completions ignored
    apply_reset();
    do_alloc(5'd7, 32'h300, 2'd0);
    do_alloc(5'd8, 32'h304, 2'd1);
    set_eu(0, 2'd1, 32'hAA, 1'b0, 32'h0);
    set_eu(2, 2'd1, 32'hBB, 1'b0, 32'h0);
    set_eu(3, 2'd0, 32'h11, 1'b0, 32'h0);
    step();
    check("prio_head_data", 64'(commit_data), 64'h11);
    commit_ready = 1'b1;
    set_eu(2, 2'd1, 32'hCC, 1'b0, 32'h0);
    set_eu(0, 2'd2, 32'h77, 1'b1, 32'h0);
    step();
    check("prio_commit_data", 64'(commit_data), 64'hAA);
    check("prio_redirect_valid", 64'(redirect_valid), 64'd0);
    step();
    commit_ready = 1'b0;
    do_alloc(5'd9, 32'h308, 2'd2);
    check("unalloc_ignored_cv", 64'(commit_valid), 64'd0);
    check("unalloc_count", 64'(count), 64'd1);

    // redirect flush
    apply_reset();
    for (int k = 0; k < DEPTH; k++) do_alloc(5'(k + 1), 32'h400 + 32'(4 * k), TAG_W'(k));
    set_eu(0, 2'd1, 32'h21, 1'b1, 32'h8000_0100);
    set_eu(1, 2'd0, 32'h20, 1'b0, 32'h0);
    step();
    check("redir_head0_cv", 64'(commit_valid), 64'd1);
    check("redir_head0_rv", 64'(redirect_valid), 64'd0);
    commit_ready = 1'b1;
    step();
    check("redir_cv", 64'(commit_valid), 64'd1);
    check("redir_rv", 64'(redirect_valid), 64'd1);
    check("redir_pc", 64'(redirect_pc), 64'h8000_0100);
    check("redir_alloc_ready", 64'(alloc_ready), 64'd0);
    alloc_valid = 1'b1;
    set_eu(2, 2'd2, 32'h55, 1'b0, 32'h0);
    step();
    commit_ready = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_cv", 64'(commit_valid), 64'd0);
    check("flush_rv", 64'(redirect_valid), 64'd0);
    check("flush_alloc_tag", 64'(alloc_tag), 64'd2);
    check("flush_alloc_ready", 64'(alloc_ready), 64'd1);
    do_alloc(5'd3, 32'h500, 2'd2);
    check("flush_new_entry_cv", 64'(commit_valid), 64'd0);

    // full buffer: commit taken, alloc refused, then tail wraps
    apply_reset();
    for (int k = 0; k < DEPTH; k++) do_alloc(5'(k + 1), 32'h600 + 32'(4 * k), TAG_W'(k));
    set_eu(0, 2'd0, 32'h61, 1'b0, 32'h0);
    step();
    check("wrap_cv", 64'(commit_valid), 64'd1);
    commit_ready = 1'b1;
    alloc_valid  = 1'b1;
    #1;
    check("wrap_alloc_ready_full", 64'(alloc_ready), 64'd0);
    step();
    commit_ready = 1'b0;
    check("wrap_count_after_commit", 64'(count), 64'd3);
    do_alloc(5'd5, 32'h610, 2'd0);
    check("wrap_count_refill", 64'(count), 64'd4);

    // asynchronous reset mid-stream
    apply_reset();
    for (int k = 0; k < 3; k++) do_alloc(5'(k + 1), 32'h700 + 32'(4 * k), TAG_W'(k));
    set_eu(0, 2'd0, 32'h71, 1'b0, 32'h0);
    step();
    check("mid_count_pre", 64'(count), 64'd3);
    check("mid_cv_pre", 64'(commit_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_count_rst", 64'(count), 64'd0);
    check("mid_cv_rst", 64'(commit_valid), 64'd0);
    check("mid_alloc_ready_rst", 64'(alloc_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    do_alloc(5'd1, 32'h800, 2'd0);
    check("mid_count_post", 64'(count), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/commit_rob.md
COMMIT_ROB -- requirements
Module: commit_rob

Interface
REQ-001 SHALL have parameter DEPTH, default 8, reorder entries (power of two, >=2).
REQ-002 SHALL have parameter NUM_EU, default 4, execution-unit completion channels.
REQ-003 SHALL have parameter XLEN, default offnariscv_pkg XLEN, data/PC width; TAG_W = $clog2(DEPTH).
REQ-004 SHALL have one clock and asynchronous active-low reset, ports: clk input 1 (rising edge), rst input 1 (asynchronous, active-low).
REQ-005 alloc_valid input 1, alloc_ready output 1: dispatch allocation handshake.
REQ-006 alloc_rd input 5, alloc_pc input XLEN: destination register and instruction PC.
REQ-007 alloc_tag output TAG_W: tag of the entry being allocated (current tail).
REQ-008 eu_valid input NUM_EU, eu_tag input NUM_EU*TAG_W, eu_data input NUM_EU*XLEN: per-channel completion.
REQ-009 eu_redirect input NUM_EU, eu_target input NUM_EU*XLEN: per-channel redirect request and target.
REQ-010 commit_valid output 1, commit_ready input 1, commit_rd output 5, commit_data output XLEN, commit_pc output XLEN: in-order retire.
REQ-011 redirect_valid output 1, redirect_pc output XLEN: redirect to PC generator, qualified by commit handshake.
REQ-012 count output TAG_W+1: occupied entries.

Function
REQ-013 Circular buffer with head/tail pointers of TAG_W bits, wrapping DEPTH-1 -> 0; count tracked separately (0..DEPTH).
REQ-014 alloc_ready = (count != DEPTH) && !(commit_valid && head redirect); no combinational path from commit_ready.
REQ-015 Allocation handshake: write rd, pc, done=0, redirect=0 at tail; tail+1; alloc_tag = tail during the handshake cycle.
REQ-016 Completion: eu_valid[i] with tag of an allocated, not-done entry writes data, redirect, target, sets done; completions on unallocated or already-done tags are ignored.
REQ-017 Same-cycle completions to distinct tags all take effect; same tag: lowest channel index wins.
REQ-018 commit_valid = head entry allocated and done; commit_rd/data/pc from head; earliest commit_valid is the cycle after completion.
REQ-019 Commit handshake (commit_valid && commit_ready): head+1, count-1; stalled commit holds outputs stable.
REQ-020 redirect_valid = commit_valid && head redirect; redirect_pc = head target.
REQ-021 Redirect commit handshake: flush all entries (done cleared), head=tail=old head+1, count=0; same-cycle allocation and completions are discarded.
REQ-022 Simultaneous alloc and non-redirect commit: count unchanged, both pointers advance, including when full (alloc_ready already low when full, so no alloc).
REQ-023 count = allocations - commits, never exceeds DEPTH, never underflows.

Reset
REQ-024 On rst low (asynchronous): head=0, tail=0, count=0, all done/redirect bits 0; entry data/rd/pc/target need no reset.
REQ-025 Reset outputs: alloc_ready=1, alloc_tag=0, commit_valid=0, redirect_valid=0, count=0; other outputs don't-care.
REQ-026 Reset assertion mid-operation discards all entries; first cycle after release behaves as empty.

Structure
REQ-027 rob_entry_t (rd, pc, data, target, done, redirect) and default ROB depth constant SHALL live in offnariscv_pkg.
REQ-028 Single flat module; no sub-module; entry storage as a register array indexed by tag.

Verification
REQ-029 DEPTH=4: allocate 4 with commit_ready=0 -> tags 0,1,2,3, count=4, alloc_ready=0 on fifth.
REQ-030 Allocate tags 0,1,2; complete 2, then 1, then 0 with data 0x30,0x20,0x10 -> commits in order 0x10,0x20,0x30, commit_valid only after tag 0 completes.
REQ-031 Channels 0 and 2 complete tag 1 same cycle with 0xAA/0xBB -> commit_data 0xAA.
REQ-032 Tags 0..3 allocated, tag 1 completes with redirect target 0x8000_0100 -> after tag 0 commit, redirect_valid=1, redirect_pc=0x8000_0100; after handshake count=0, next alloc_tag=2.
REQ-033 Full buffer, commit and alloc attempted same cycle -> commit taken, alloc refused, count=3; next cycle alloc accepted, tag wraps to 0.
REQ-034 Assert rst mid-stream with count=3 -> count=0, commit_valid=0 immediately; after release first alloc_tag=0.
